// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32 funct3 size codes, FSM states, size helpers.
// ACC2 only exists when LSU_MISALIGNED_EN is defined.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, RESP = 2'd3} state_t;
`endif

    // Reserved codes report size 0 so they can never look like a spanning access.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            F3_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: store lane shift / byte-enable generation and load byte select, merge and extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when outputs are used.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        second,
    input  logic [31:0] st_data,
    output logic [31:0] wr_data,
    output logic [3:0]  byte_en,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);

    logic [7:0]  mask;
    logic [31:0] st_sized;
    logic [63:0] st_wide;
    logic [63:0] ld_wide;
    logic [31:0] raw;

    // A word plus its successor is treated as one 8-lane window so split accesses fall out of a shift.
    always_comb begin
        mask     = 8'h00;
        st_sized = st_data;
        case (size_bytes(funct3))
            3'd1: begin mask = 8'h01; st_sized = {24'b0, st_data[7:0]};  end
            3'd2: begin mask = 8'h03; st_sized = {16'b0, st_data[15:0]}; end
            3'd4: mask = 8'h0F;
            default: mask = 8'h00;
        endcase
        mask    = mask << offset;
        st_wide = {32'b0, st_sized} << {offset, 3'b000};
        wr_data = second ? st_wide[63:32] : st_wide[31:0];
        byte_en = second ? mask[7:4] : mask[3:0];

        ld_wide = {ld_hi, ld_lo} >> {offset, 3'b000};
        raw     = ld_wide[31:0];
        case (funct3)
            F3_B:    ld_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ld_data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ld_data = {24'b0, raw[7:0]};
            F3_HU:   ld_data = {16'b0, raw[15:0]};
            default: ld_data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: RV32 load/store unit; splits word-spanning accesses when LSU_MISALIGNED_EN is defined, else rejects them.
// Latency: accept to rsp_valid 2 cycles aligned, 3 split, 1 for rejected requests.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_byte_en
);

    state_t                state;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  in_acc;
    logic                  in_second;
    logic                  req_span;
    logic                  req_bad;
    logic [DATA_WIDTH-1:0] ld_lo;
    logic [DATA_WIDTH-1:0] ld_hi;
    logic [DATA_WIDTH-1:0] al_wr_data;
    logic [3:0]            al_byte_en;
    logic [DATA_WIDTH-1:0] ld_data;

    assign req_ready = (state == IDLE);
    assign base      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign req_span  = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;

`ifdef LSU_MISALIGNED_EN
    logic                  r_span;
    logic [DATA_WIDTH-1:0] lo_word;

    assign req_bad   = !f3_legal(req_we, req_funct3);
    assign in_second = (state == ACC2);
    assign in_acc    = (state == ACC1) || (state == ACC2);
    assign acc_addr  = in_second ? base + ADDR_WIDTH'(4) : base;
    assign ld_lo     = in_second ? lo_word : mem_rd_data;
    assign ld_hi     = in_second ? mem_rd_data : '0;
`else
    assign req_bad   = !f3_legal(req_we, req_funct3) || req_span;
    assign in_second = 1'b0;
    assign in_acc    = (state == ACC1);
    assign acc_addr  = base;
    assign ld_lo     = mem_rd_data;
    assign ld_hi     = '0;
`endif

    assign mem_addr    = in_acc ? acc_addr : '0;
    assign mem_wr_addr = in_acc ? acc_addr : '0;
    assign mem_wr_en   = in_acc && r_we;
    assign mem_byte_en = mem_wr_en ? al_byte_en : 4'b0000;
    assign mem_wr_data = mem_wr_en ? al_wr_data : '0;

    lsu_align u_align (
        .funct3  (r_f3),
        .offset  (r_addr[1:0]),
        .second  (in_second),
        .st_data (r_wdata),
        .wr_data (al_wr_data),
        .byte_en (al_byte_en),
        .ld_lo   (ld_lo),
        .ld_hi   (ld_hi),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_f3      <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef LSU_MISALIGNED_EN
            r_span    <= 1'b0;
            lo_word   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
`ifdef LSU_MISALIGNED_EN
                        r_span  <= req_span;
`endif
                        // Rejected requests never touch memory.
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ACC1;
                        end
                    end
                end
                ACC1: begin
`ifdef LSU_MISALIGNED_EN
                    if (r_span) begin
                        lo_word <= mem_rd_data;
                        state   <= ACC2;
                    end else
`endif
                    begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_we ? '0 : ld_data;
                    end
                end
`ifdef LSU_MISALIGNED_EN
                ACC2: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_we ? '0 : ld_data;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a byte-lane memory model.
// Covers both the default build and LSU_MISALIGNED_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic        mem_clr = 1'b1;
    logic [31:0] mem [0:1023];
    logic [31:0] ra2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en)
    );

    assign mem_rd_data = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem[mem_wr_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nw;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] wa1;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic [31:0] wa2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vl(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                                input logic err, input int lat);
        vec_t v;
        v = '{we: 1'b0, f3: f3, addr: a, wdata: 32'h0, exp_rdata: rd, exp_err: err, exp_lat: lat,
              exp_nw: 0, be1: 4'h0, wd1: 32'h0, wa1: 32'h0, be2: 4'h0, wd2: 32'h0, wa2: 32'h0};
        return v;
    endfunction

    function automatic vec_t vs(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                input logic err, input int lat, input int nw,
                                input logic [3:0] b1, input logic [31:0] d1, input logic [31:0] a1,
                                input logic [3:0] b2, input logic [31:0] d2, input logic [31:0] a2);
        vec_t v;
        v = '{we: 1'b1, f3: f3, addr: a, wdata: wd, exp_rdata: 32'h0, exp_err: err, exp_lat: lat,
              exp_nw: nw, be1: b1, wd1: d1, wa1: a1, be2: b2, wd2: d2, wa2: a2};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int hold);
        int          k;
        int          nw;
        logic        bad;
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        logic [31:0] wa [2];
        for (int i = 0; i < 2; i++) begin be[i] = '0; wd[i] = '0; wa[i] = '0; end
        chk("idle_req_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
        k = 1; nw = 0; bad = 1'b0; ra2 = '0;
        while (!rsp_valid && k < 12) begin
            if (mem_wr_en) begin
                if (nw < 2) begin be[nw] = mem_byte_en; wd[nw] = mem_wr_data; wa[nw] = mem_wr_addr; end
                nw++;
            end
            if (!mem_wr_en && mem_byte_en != 4'b0000) bad = 1'b1;
            if (k == 2) ra2 = mem_addr;
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, v.exp_lat);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("num_writes", nw, v.exp_nw);
        chk("wr1_byte_en", 32'(be[0]), 32'(v.be1));
        chk("wr1_data", wd[0], v.wd1);
        chk("wr1_addr", wa[0], v.wa1);
        chk("wr2_byte_en", 32'(be[1]), 32'(v.be2));
        chk("wr2_data", wd[1], v.wd2);
        chk("wr2_addr", wa[1], v.wa2);
        chk("byte_en_gated", 32'(bad), 0);
        chk("resp_req_ready", 32'(req_ready), 0);
        chk("resp_wr_en", 32'(mem_wr_en), 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_hs_rsp_valid", 32'(rsp_valid), 0);
    endtask

    task automatic reset_mid(input logic [31:0] addr, input int at_k);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k < at_k; k++) begin @(posedge clk); #1; end
        chk("mid_wr_en_before_rst", 32'(mem_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(mem_wr_en), 0);
        chk("mid_rst_byte_en", 32'(mem_byte_en), 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_wr_addr", mem_wr_addr, 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        tbl.push_back(vs(3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 1, 4'hF, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b010, 32'h100, 32'hDEADBEEF, 0, 2));
        tbl.push_back(vs(3'b000, 32'h103, 32'h00000080, 0, 2, 1, 4'h8, 32'h80000000, 32'h100, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b000, 32'h103, 32'hFFFFFF80, 0, 2));
        tbl.push_back(vl(3'b100, 32'h103, 32'h00000080, 0, 2));
        tbl.push_back(vs(3'b001, 32'h102, 32'h0000A5B6, 0, 2, 1, 4'hC, 32'hA5B60000, 32'h100, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b001, 32'h102, 32'hFFFFA5B6, 0, 2));
        tbl.push_back(vl(3'b101, 32'h102, 32'h0000A5B6, 0, 2));
        tbl.push_back(vl(3'b000, 32'h101, 32'hFFFFFFBE, 0, 2));
        tbl.push_back(vl(3'b100, 32'h100, 32'h000000EF, 0, 2));
        tbl.push_back(vs(3'b000, 32'h200, 32'h12345677, 0, 2, 1, 4'h1, 32'h00000077, 32'h200, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b010, 32'h200, 32'h00000077, 0, 2));
        tbl.push_back(vl(3'b011, 32'h100, 32'h0, 1, 1));
        tbl.push_back(vs(3'b100, 32'h100, 32'hFFFFFFFF, 1, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vs(3'b011, 32'h100, 32'hFFFFFFFF, 1, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b010, 32'h100, 32'hA5B6BEEF, 0, 2));
        tbl.push_back(vs(3'b001, 32'h002, 32'h00008001, 0, 2, 1, 4'hC, 32'h80010000, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b001, 32'h002, 32'hFFFF8001, 0, 2));
        tbl.push_back(vl(3'b100, 32'h003, 32'h00000080, 0, 2));
`ifdef LSU_MISALIGNED_EN
        tbl.push_back(vs(3'b010, 32'h201, 32'h11223344, 0, 3, 2, 4'hE, 32'h22334400, 32'h200, 4'h1, 32'h00000011, 32'h204));
        tbl.push_back(vl(3'b010, 32'h201, 32'h11223344, 0, 3));
        tbl.push_back(vl(3'b001, 32'h003, 32'h00000080, 0, 3));
        tbl.push_back(vs(3'b010, 32'hFFFFFFFE, 32'h44332211, 0, 3, 2, 4'hC, 32'h22110000, 32'hFFFFFFFC, 4'h3, 32'h00004433, 32'h0));
`else
        tbl.push_back(vl(3'b001, 32'h003, 32'h0, 1, 1));
        tbl.push_back(vs(3'b010, 32'h201, 32'h11223344, 1, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vl(3'b010, 32'h200, 32'h00000077, 0, 2));
        tbl.push_back(vl(3'b010, 32'hFFFFFFFE, 32'h0, 1, 1));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        chk("rst_byte_en", 32'(mem_byte_en), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], 0);

        run(vl(3'b010, 32'h100, 32'hA5B6BEEF, 0, 2), 5);

`ifdef LSU_MISALIGNED_EN
        run(vl(3'b010, 32'hFFFFFFFE, 32'h44332211, 0, 3), 0);
        chk("acc2_wrap_addr", ra2, 32'h0);
        reset_mid(32'h501, 2);
        run(vl(3'b010, 32'h504, 32'h0, 0, 2), 0);
        run(vl(3'b010, 32'h500, 32'hFEF00D00, 0, 2), 0);
`else
        reset_mid(32'h500, 1);
        run(vl(3'b010, 32'h500, 32'h0, 0, 2), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-004 SHALL have these request ports:
- req_valid input 1, request present.
- req_ready output 1, unit can accept a request.
- req_we input 1, 1=store, 0=load.
- req_funct3 input 3, RV32 size/sign code.
- req_addr input ADDR_WIDTH, byte address.
- req_wdata input DATA_WIDTH, store data, right-justified.
REQ-005 SHALL have these response ports:
- rsp_valid output 1, response present.
- rsp_ready input 1, consumer accepts the response.
- rsp_rdata output DATA_WIDTH, extended load data; 0 for stores.
- rsp_err output 1, misaligned access rejected.
REQ-006 SHALL have these memory ports:
- mem_addr output ADDR_WIDTH, word-aligned read address.
- mem_rd_data input DATA_WIDTH, combinational read data for mem_addr.
- mem_wr_en output 1, write strobe.
- mem_wr_addr output ADDR_WIDTH, word-aligned write address.
- mem_wr_data output DATA_WIDTH, lane-aligned store data.
- mem_byte_en output 4, byte-lane enables.

Function
REQ-007 SHALL implement FSM states IDLE, ACC1, ACC2, RESP.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&&req_ready.
REQ-009 On acceptance SHALL register we/funct3/addr/wdata and go to ACC1.
REQ-010 In ACC1 SHALL drive mem_addr = mem_wr_addr = {addr[31:2],2'b00}; store lanes/data are shifted by addr[1:0].
REQ-011 A load SHALL capture mem_rd_data at the end of ACC1; a store SHALL assert mem_wr_en for exactly the ACC1 cycle.
REQ-012 An access SHALL be treated as spanning when addr[1:0]+size_bytes > 4.
REQ-013 From ACC1 SHALL go to ACC2 if spanning, otherwise to RESP.
REQ-014 ACC2 SHALL access word base+4, computed modulo 2^ADDR_WIDTH: remaining high lanes from lane 0, loads merged with the ACC1 bytes.
REQ-015 In RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then return to IDLE.
REQ-016 The next request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-017 Loads SHALL be extended per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
REQ-018 Stores SHALL use funct3 000 SB, 001 SH, 010 SW.
REQ-019 Reserved funct3 codes SHALL set rsp_err=1 and SHALL NOT assert mem_wr_en.
REQ-020 mem_wr_en SHALL be 0 in IDLE, RESP, and for all loads; mem_byte_en SHALL be 0 whenever mem_wr_en=0.
REQ-021 Latency from acceptance to rsp_valid SHALL be 2 cycles aligned, 3 cycles spanning.

Reset
REQ-022 While rst_n=0 the unit SHALL hold state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wr_en=0, mem_byte_en=0, and mem_addr=mem_wr_addr=0.
REQ-023 Reset asserted in any state, including mid-split, SHALL abort the transaction with no further write; req_ready=1 in the first cycle after release.

Configuration
REQ-024 With LSU_MISALIGNED_EN defined, spanning accesses SHALL be split per REQ-013..REQ-014 with rsp_err=0.
REQ-025 Without LSU_MISALIGNED_EN, spanning accesses SHALL skip ACC1/ACC2 and go straight to RESP with rsp_err=1, rsp_rdata=0, and no memory write.
REQ-026 Without LSU_MISALIGNED_EN, the ACC2 state and its logic SHALL be absent.

Structure
REQ-027 Package lsu_pkg SHALL hold the funct3 encodings as localparams/enum, the FSM state enum, and the function size_bytes(funct3).
REQ-028 Sub-module lsu_align SHALL be purely combinational: store lane shift/byte_en generation and load byte select/merge/extend.

Verification
REQ-029 SW 0xDEADBEEF at 0x100, then LW 0x100 -> byte_en 1111 at 0x100, then rsp_rdata 0xDEADBEEF, latency 2, rsp_err 0.
REQ-030 SB 0x80 at 0x103, then LB 0x103 and LBU 0x103 -> byte_en 1000, then 0xFFFFFF80 and 0x00000080.
REQ-031 With LSU_MISALIGNED_EN, SW 0x11223344 at 0x201 -> ACC1 at 0x200 byte_en 1110 data 0x22334400; ACC2 at 0x204 byte_en 0001 data 0x00000011; LW 0x201 returns 0x11223344, latency 3.
REQ-032 Without LSU_MISALIGNED_EN, LH at 0x3 -> rsp_err 1, rsp_rdata 0, no mem_wr_en; aligned LH at 0x2 is unaffected.
REQ-033 With LSU_MISALIGNED_EN, LW at 0xFFFFFFFE -> ACC2 reads 0x00000000.
REQ-034 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable and req_ready 0 throughout.
REQ-035 rst_n pulsed low in ACC2 of a split store -> no ACC2 write, IDLE, req_ready 1 after release.
